// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port synchronous RAM; port A read/write with byte enables, port B read-only.
// A clear engine zeroes the array after reset; define RAM_INIT_FILE_EN to skip the clear engine.
module ram_dp_be #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 64,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_MODE    = 0,
    parameter     INIT_FILE     = ""
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       busy,
    input  logic                       a_en,
    input  logic [DATA_WIDTH/8-1:0]    a_wen,
    input  logic [ADDRESS_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]      a_din,
    output logic [DATA_WIDTH-1:0]      a_dout,
    output logic                       a_valid,
    input  logic                       b_en,
    input  logic [ADDRESS_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]      b_dout,
    output logic                       b_valid,
    output logic                       oob_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM_INIT_FILE_EN
    localparam state_t RST_STATE = RUN;
`else
    localparam state_t RST_STATE = CLEAR;
`endif
    logic unused_init;
    assign unused_init = ^INIT_FILE;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   clr_cnt_reg, clr_cnt_next;

    logic               run;
    logic               clear_we;
    logic               a_acc, a_wr_acc, a_rd_acc, a_oob;
    logic               b_acc, b_oob, b_coll;
    logic [IDX_W-1:0]   a_idx, b_idx, wr_idx;
    logic [NB-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_data, b_merged;

    logic [DATA_WIDTH-1:0] a_q1_reg, b_q1_reg;
    logic               a_v1_reg, b_v1_reg;
    logic               oob_err_reg;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= RST_STATE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == IDX_W'(DEPTH - 1)) begin
                state_next   = RUN;
                clr_cnt_next = '0;
            end
        end
    end

    assign busy     = (state_reg == CLEAR);
    assign run      = (state_reg == RUN) && !reset;
    assign clear_we = (state_reg == CLEAR) && !reset;

    // ---------------- request decode ----------------
    assign a_oob    = {1'b0, a_addr} >= (ADDRESS_WIDTH + 1)'(DEPTH);
    assign b_oob    = {1'b0, b_addr} >= (ADDRESS_WIDTH + 1)'(DEPTH);
    assign a_idx    = a_addr[IDX_W-1:0];
    assign b_idx    = b_addr[IDX_W-1:0];
    assign a_acc    = a_en && run;
    assign a_wr_acc = a_acc && (|a_wen);
    assign a_rd_acc = a_acc && !(|a_wen);
    assign b_acc    = b_en && run;

    // Write-first collisions bypass the array with the byte-merged word.
    assign b_coll   = (WRITE_MODE == 1) && a_wr_acc && !a_oob && b_acc && (a_addr == b_addr);

    // Single write port shared by the clear engine and port A.
    assign wr_idx   = clear_we ? clr_cnt_reg : a_idx;
    assign wr_data  = clear_we ? '0 : a_din;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wr_be[gi] = clear_we | (a_wr_acc & ~a_oob & a_wen[gi]);
            assign b_merged[gi*8 +: 8] = a_wen[gi] ? a_din[gi*8 +: 8] : mem[b_idx][gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // ---------------- first read stage ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q1_reg <= '0;
            b_q1_reg <= '0;
            a_v1_reg <= 1'b0;
            b_v1_reg <= 1'b0;
        end else begin
            a_v1_reg <= a_rd_acc;
            b_v1_reg <= b_acc;
            if (a_rd_acc) begin
                a_q1_reg <= a_oob ? '0 : mem[a_idx];
            end
            if (b_acc) begin
                b_q1_reg <= b_oob ? '0 : (b_coll ? b_merged : mem[b_idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err_reg <= 1'b0;
        end else if ((a_acc && a_oob) || (b_acc && b_oob)) begin
            oob_err_reg <= 1'b1;
        end
    end

    assign oob_err = oob_err_reg;

    // ---------------- optional output stage ----------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] a_q2_reg, b_q2_reg;
            logic                  a_v2_reg, b_v2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q2_reg <= '0;
                    b_q2_reg <= '0;
                    a_v2_reg <= 1'b0;
                    b_v2_reg <= 1'b0;
                end else begin
                    a_v2_reg <= a_v1_reg;
                    b_v2_reg <= b_v1_reg;
                    if (a_v1_reg) a_q2_reg <= a_q1_reg;
                    if (b_v1_reg) b_q2_reg <= b_q1_reg;
                end
            end

            assign a_dout  = a_q2_reg;
            assign a_valid = a_v2_reg;
            assign b_dout  = b_q2_reg;
            assign b_valid = b_v2_reg;
        end else begin : g_lat1
            assign a_dout  = a_q1_reg;
            assign a_valid = a_v1_reg;
            assign b_dout  = b_q1_reg;
            assign b_valid = b_v1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (latency 1 read-first, latency 2 write-first) share stimulus
// and are checked against a transaction-level memory model.
module tb_ram_dp_be;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            a_en = 1'b0;
    logic [3:0]      a_wen = 4'h0;
    logic [AW-1:0]   a_addr = '0;
    logic [DW-1:0]   a_din = '0;
    logic            b_en = 1'b0;
    logic [AW-1:0]   b_addr = '0;

    logic [1:0]      busy_w, av, bv, oob_w;
    logic [DW-1:0]   ad [2];
    logic [DW-1:0]   bd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dp_be #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
                .READ_LATENCY(1), .WRITE_MODE(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .busy(busy_w[0]),
        .a_en(a_en), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
        .a_dout(ad[0]), .a_valid(av[0]),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd[0]), .b_valid(bv[0]),
        .oob_err(oob_w[0]));

    ram_dp_be #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
                .READ_LATENCY(2), .WRITE_MODE(1), .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset), .busy(busy_w[1]),
        .a_en(a_en), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
        .a_dout(ad[1]), .a_valid(av[1]),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd[1]), .b_valid(bv[1]),
        .oob_err(oob_w[1]));

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          k;
        bit          is_b;
        logic [31:0] d;
    } pend_t;

    logic [31:0] mmem [DEPTH];
    pend_t       pq [$];
    int          edge_n = 0;
    int          busy_left = DEPTH;
    bit          m_oob = 1'b0;
    bit          exp_av [2] = '{1'b0, 1'b0};
    bit          exp_bv [2] = '{1'b0, 1'b0};
    logic [31:0] exp_ad [2] = '{32'h0, 32'h0};
    logic [31:0] exp_bd [2] = '{32'h0, 32'h0};

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic void push(int k, bit is_b, logic [31:0] d);
        pend_t p;
        p.due  = edge_n + lat_of(k) - 1;
        p.k    = k;
        p.is_b = is_b;
        p.d    = d;
        pq.push_back(p);
    endfunction

    // Instance 0 sees pre-write data on a collision, instance 1 sees post-write data.
    function automatic void model_edge();
        logic [31:0] a_rd, b_old, b_new;
        bit a_in, b_in;
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            exp_av[k] = 1'b0;
            exp_bv[k] = 1'b0;
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
            busy_left = DEPTH;
            m_oob = 1'b0;
            pq.delete();
            for (int k = 0; k < 2; k++) begin
                exp_ad[k] = 32'h0;
                exp_bd[k] = 32'h0;
            end
            return;
        end
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            a_in = int'(a_addr) < DEPTH;
            b_in = int'(b_addr) < DEPTH;
            if ((a_en && !a_in) || (b_en && !b_in)) m_oob = 1'b1;
            b_old = b_in ? mmem[b_addr[5:0]] : 32'h0;
            if (a_en && a_wen == 4'h0) begin
                a_rd = a_in ? mmem[a_addr[5:0]] : 32'h0;
                push(0, 1'b0, a_rd);
                push(1, 1'b0, a_rd);
            end
            if (a_en && a_wen != 4'h0 && a_in) begin
                for (int i = 0; i < 4; i++)
                    if (a_wen[i]) mmem[a_addr[5:0]][8*i +: 8] = a_din[8*i +: 8];
            end
            b_new = b_in ? mmem[b_addr[5:0]] : 32'h0;
            if (b_en) begin
                push(0, 1'b1, b_old);
                push(1, 1'b1, b_new);
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].due == edge_n) begin
                if (pq[i].is_b) begin
                    exp_bv[pq[i].k] = 1'b1;
                    exp_bd[pq[i].k] = pq[i].d;
                end else begin
                    exp_av[pq[i].k] = 1'b1;
                    exp_ad[pq[i].k] = pq[i].d;
                end
                pq.delete(i);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        a_en  = 1'b0;
        a_wen = 4'h0;
        b_en  = 1'b0;
    endtask

    task automatic write_a(input int addr, input logic [31:0] d, input logic [3:0] be);
        a_en = 1'b1; a_wen = be; a_addr = AW'(addr); a_din = d;
        step();
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        reset = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_w[k] !== 1'b1 || av[k] !== 1'b0 || bv[k] !== 1'b0 ||
                ad[k] !== 32'h0 || bd[k] !== 32'h0 || oob_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got busy=%b av=%b bv=%b ad=%h bd=%h oob=%b want 1 0 0 0 0 0",
                         k, busy_w[k], av[k], bv[k], ad[k], bd[k], oob_w[k]);
            end
        end
        reset = 1'b0;
        n = 0;
        while (busy_w[0] && n < 200) begin
            step();
            n++;
            checks++;
            if (busy_w[1] !== busy_w[0] || busy_w[0] !== (busy_left > 0)) begin
                errors++;
                $display("FAIL clear_busy_track: got %b/%b want %b", busy_w[0], busy_w[1], busy_left > 0);
            end
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d want %0d", n, DEPTH);
        end
        $display("clear: busy cycles=%0d", n);
        b_en = 1'b1; b_addr = AW'(63);
        step();
        idle();
        checks++;
        if (bv[0] !== 1'b1 || bd[0] !== 32'h0) begin
            errors++;
            $display("FAIL clear_read63_l1: got v=%b d=%h want 1 00000000", bv[0], bd[0]);
        end
        step();
        checks++;
        if (bv[1] !== 1'b1 || bd[1] !== 32'h0 || bv[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_read63_l2: got v=%b d=%h v0=%b want 1 00000000 0", bv[1], bd[1], bv[0]);
        end
    endtask

    task automatic test_byte_enable();
        write_a(5, 32'hAABBCCDD, 4'b1111);
        write_a(5, 32'h11223344, 4'b0101);
        checks++;
        if (av !== 2'b00) begin
            errors++;
            $display("FAIL write_no_valid: got %b want 00", av);
        end
        a_en = 1'b1; a_wen = 4'h0; a_addr = AW'(5);
        step();
        idle();
        checks++;
        if (av[0] !== 1'b1 || ad[0] !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL byte_en_l1: got v=%b d=%h want 1 aa22cc44", av[0], ad[0]);
        end
        step();
        checks++;
        if (av[1] !== 1'b1 || ad[1] !== 32'hAA22CC44 || av[0] !== 1'b0) begin
            errors++;
            $display("FAIL byte_en_l2: got v=%b d=%h v0=%b want 1 aa22cc44 0", av[1], ad[1], av[0]);
        end
        $display("byte_en: addr5 = %h / %h", ad[0], ad[1]);
    endtask

    task automatic test_collision();
        write_a(7, 32'h0, 4'b1111);
        a_en = 1'b1; a_wen = 4'b1111; a_addr = AW'(7); a_din = 32'hDEADBEEF;
        b_en = 1'b1; b_addr = AW'(7);
        step();
        idle();
        checks++;
        if (bv[0] !== 1'b1 || bd[0] !== 32'h0) begin
            errors++;
            $display("FAIL collision_read_first: got v=%b d=%h want 1 00000000", bv[0], bd[0]);
        end
        step();
        checks++;
        if (bv[1] !== 1'b1 || bd[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL collision_write_first: got v=%b d=%h want 1 deadbeef", bv[1], bd[1]);
        end
        $display("collision: mode0=%h mode1=%h", bd[0], bd[1]);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        bit want;
        vals[0] = 32'h1111_0001;
        vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) write_a(i + 1, vals[i], 4'b1111);
        for (int s = 0; s < 5; s++) begin
            if (s < 3) begin
                b_en = 1'b1; b_addr = AW'(s + 1);
            end else begin
                b_en = 1'b0;
            end
            step();
            want = (s >= 1 && s <= 3);
            checks++;
            if (bv[1] !== want) begin
                errors++;
                $display("FAIL b2b_valid_l2[%0d]: got %b want %b", s, bv[1], want);
            end
            if (want) begin
                checks++;
                if (bd[1] !== vals[s-1]) begin
                    errors++;
                    $display("FAIL b2b_data_l2[%0d]: got %h want %h", s, bd[1], vals[s-1]);
                end
            end
            checks++;
            if (bv[0] !== (s <= 2) || (s <= 2 && bd[0] !== exp_bd[0])) begin
                errors++;
                $display("FAIL b2b_l1[%0d]: got v=%b d=%h want %b %h", s, bv[0], bd[0], s <= 2, exp_bd[0]);
            end
            $display("b2b: cycle %0d bv=%b bd1=%h", s, bv, bd[1]);
        end
        idle();
    endtask

    task automatic test_oob();
        write_a(64, 32'h12345678, 4'b1111);
        checks++;
        if (oob_w !== 2'b11 || m_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_set: got %b want 11", oob_w);
        end
        a_en = 1'b1; a_wen = 4'h0; a_addr = AW'(0);
        b_en = 1'b1; b_addr = AW'(64);
        step();
        idle();
        checks++;
        if (av[0] !== 1'b1 || ad[0] !== 32'h0 || bv[0] !== 1'b1 || bd[0] !== 32'h0) begin
            errors++;
            $display("FAIL oob_reads: got av=%b ad=%h bv=%b bd=%h want 1 00000000 1 00000000",
                     av[0], ad[0], bv[0], bd[0]);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (oob_w !== 2'b11) begin
                errors++;
                $display("FAIL oob_sticky[%0d]: got %b want 11", i, oob_w);
            end
        end
        $display("oob: flag=%b", oob_w);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_en   = ($urandom_range(0, 3) != 0);
            a_wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            a_addr = AW'($urandom_range(0, 70));
            a_din  = $urandom;
            b_en   = ($urandom_range(0, 3) != 0);
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 70));
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (av[k] !== exp_av[k] || ad[k] !== exp_ad[k]) begin
                    errors++;
                    $display("FAIL rand_a[%0d] cyc %0d: got v=%b d=%h want %b %h",
                             k, c, av[k], ad[k], exp_av[k], exp_ad[k]);
                end
                checks++;
                if (bv[k] !== exp_bv[k] || bd[k] !== exp_bd[k]) begin
                    errors++;
                    $display("FAIL rand_b[%0d] cyc %0d: got v=%b d=%h want %b %h",
                             k, c, bv[k], bd[k], exp_bv[k], exp_bd[k]);
                end
                checks++;
                if (busy_w[k] !== 1'b0 || oob_w[k] !== m_oob) begin
                    errors++;
                    $display("FAIL rand_status[%0d] cyc %0d: got busy=%b oob=%b want 0 %b",
                             k, c, busy_w[k], oob_w[k], m_oob);
                end
            end
        end
        idle();
        $display("random: 400 cycles done, oob=%b", oob_w);
    endtask

    task automatic test_mid_clear();
        int n;
        bit saw_av;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (busy_w !== 2'b11) begin
            errors++;
            $display("FAIL midclear_busy30: got %b want 11", busy_w);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        saw_av = 1'b0;
        while (busy_w[0] && n < 200) begin
            if (n == 10) begin
                a_en = 1'b1; a_wen = 4'h0; a_addr = AW'(5);
                b_en = 1'b1; b_addr = AW'(5);
            end
            step();
            idle();
            n++;
            if (av != 2'b00 || bv != 2'b00) saw_av = 1'b1;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL midclear_busy_len: got %0d want %0d", n, DEPTH);
        end
        checks++;
        if (saw_av !== 1'b0) begin
            errors++;
            $display("FAIL midclear_ignored_req: got valid=%b want 0", saw_av);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (av !== 2'b00 || bv !== 2'b00 || oob_w !== 2'b00 || busy_w !== 2'b00) begin
                errors++;
                $display("FAIL midclear_after[%0d]: got av=%b bv=%b oob=%b busy=%b want 00 00 00 00",
                         i, av, bv, oob_w, busy_w);
            end
        end
        a_en = 1'b1; a_wen = 4'h0; a_addr = AW'(5);
        step();
        idle();
        checks++;
        if (av[0] !== 1'b1 || ad[0] !== 32'h0) begin
            errors++;
            $display("FAIL midclear_cleared: got v=%b d=%h want 1 00000000", av[0], ad[0]);
        end
        $display("mid_clear: busy cycles=%0d", n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_oob();
        test_random();
        test_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
